// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one Sysbus master port between fetch (F) and data (D), locking per transaction.
// Macros: SYSBUS_ARB_FETCH_PRIORITY_EN (fixed F priority on ties), SYSBUS_ARB_CHECK_EN (protocol assertions).
`default_nettype none
module sysbus_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_reqcyc,
  input  logic [DATA_W-1:0] f_req,
  input  logic [TAG_W-1:0]  f_reqtag,
  output logic              f_reqack,
  output logic              f_respcyc,
  output logic [DATA_W-1:0] f_resp,
  input  logic              f_respack,
  input  logic              d_reqcyc,
  input  logic [DATA_W-1:0] d_req,
  input  logic [TAG_W-1:0]  d_reqtag,
  output logic              d_reqack,
  output logic              d_respcyc,
  output logic [DATA_W-1:0] d_resp,
  input  logic              d_respack,
  output logic              m_reqcyc,
  output logic [DATA_W-1:0] m_req,
  output logic [TAG_W-1:0]  m_reqtag,
  input  logic              m_reqack,
  input  logic              m_respcyc,
  input  logic [DATA_W-1:0] m_resp,
  output logic              m_respack
);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             tie_pick;

  logic              own_reqcyc;
  logic [DATA_W-1:0] own_req;
  logic [TAG_W-1:0]  own_reqtag;
  logic              own_respack;

  assign own_reqcyc  = owner ? d_reqcyc  : f_reqcyc;
  assign own_req     = owner ? d_req     : f_req;
  assign own_reqtag  = owner ? d_reqtag  : f_reqtag;
  assign own_respack = owner ? d_respack : f_respack;

`ifdef SYSBUS_ARB_FETCH_PRIORITY_EN
  assign tie_pick = 1'b0;
`else
  logic last_grant;

  // Reset value 1 makes F win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (f_reqcyc || d_reqcyc)) begin
      last_grant <= owner_nxt;
    end
  end

  assign tie_pick = ~last_grant;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    m_reqcyc     = 1'b0;
    m_req        = '0;
    m_reqtag     = '0;
    m_respack    = 1'b0;
    f_reqack     = 1'b0;
    d_reqack     = 1'b0;
    f_respcyc    = 1'b0;
    d_respcyc    = 1'b0;
    f_resp       = '0;
    d_resp       = '0;

    case (state)
      IDLE: begin
        if (f_reqcyc || d_reqcyc) begin
          owner_nxt = (f_reqcyc && d_reqcyc) ? tie_pick : d_reqcyc;
          state_nxt = REQ;
        end
      end

      REQ: begin
        m_reqcyc = own_reqcyc;
        m_req    = own_req;
        m_reqtag = own_reqtag;
        f_reqack = ~owner & m_reqack;
        d_reqack = owner & m_reqack;
        if (!own_reqcyc) begin
          state_nxt = IDLE;
        end else if (m_reqack) begin
          state_nxt    = own_reqtag[TAG_W-1] ? RDATA : WDATA;
          beat_cnt_nxt = '0;
        end
      end

      WDATA: begin
        m_reqcyc = own_reqcyc;
        m_req    = own_req;
        m_reqtag = own_reqtag;
        f_reqack = ~owner & m_reqack;
        d_reqack = owner & m_reqack;
        if (own_reqcyc && m_reqack) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
        end
      end

      RDATA: begin
        f_resp    = m_resp;
        d_resp    = m_resp;
        m_respack = own_respack;
        if (owner) d_respcyc = m_respcyc;
        else       f_respcyc = m_respcyc;
        if (m_respcyc && own_respack) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifdef SYSBUS_ARB_CHECK_EN
  a_no_stray_resp: assert property (@(posedge clk) disable iff (!reset)
    !(m_respcyc && state != RDATA));
  a_req_held: assert property (@(posedge clk) disable iff (!reset)
    !(state == REQ && !own_reqcyc));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
// Directed-vector bench for sysbus_arbiter; the bench plays both requesters and the downstream Sysbus.
`default_nettype none
module tb_sysbus_arbiter;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 13;
  localparam int BEATS  = 8;
  localparam logic [TAG_W-1:0] F_RTAG = 13'h1001;
  localparam logic [TAG_W-1:0] D_RTAG = 13'h1002;
  localparam logic [TAG_W-1:0] D_WTAG = 13'h0003;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic              f_reqcyc = 1'b0, f_reqack, f_respcyc, f_respack = 1'b0;
  logic [DATA_W-1:0] f_req = '0, f_resp;
  logic [TAG_W-1:0]  f_reqtag = '0;
  logic              d_reqcyc = 1'b0, d_reqack, d_respcyc, d_respack = 1'b0;
  logic [DATA_W-1:0] d_req = '0, d_resp;
  logic [TAG_W-1:0]  d_reqtag = '0;
  logic              m_reqcyc, m_reqack = 1'b0, m_respcyc = 1'b0, m_respack;
  logic [DATA_W-1:0] m_req, m_resp = '0;
  logic [TAG_W-1:0]  m_reqtag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sysbus_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .f_reqcyc(f_reqcyc), .f_req(f_req), .f_reqtag(f_reqtag), .f_reqack(f_reqack),
    .f_respcyc(f_respcyc), .f_resp(f_resp), .f_respack(f_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
    .d_respcyc(d_respcyc), .d_resp(d_resp), .d_respack(d_respack),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
    .m_respcyc(m_respcyc), .m_resp(m_resp), .m_respack(m_respack)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered one cycle after the grant edge: header visible, ack arrives on its 2nd cycle.
  task automatic expect_grant(input bit port, input logic [DATA_W-1:0] addr, input logic [TAG_W-1:0] tag);
    logic [1:0] ack_exp;
    ack_exp = port ? 2'b01 : 2'b10;
    #1;
    vectors++;
    if ({m_reqcyc, m_req, m_reqtag} !== {1'b1, addr, tag}) begin
      miscompares++;
      $display("FAIL grant_hdr port=%0d: got cyc=%b req=%h tag=%h, want cyc=1 req=%h tag=%h",
               port, m_reqcyc, m_req, m_reqtag, addr, tag);
    end
    vectors++;
    if ({f_reqack, d_reqack} !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_early port=%0d: got f/d reqack=%b, want 00", port, {f_reqack, d_reqack});
    end
    tick();
    m_reqack = 1'b1;
    #1;
    vectors++;
    if ({f_reqack, d_reqack} !== ack_exp) begin
      miscompares++;
      $display("FAIL grant_ack port=%0d: got f/d reqack=%b, want %b", port, {f_reqack, d_reqack}, ack_exp);
    end
    tick();
    if (port) d_reqcyc = 1'b0;
    else      f_reqcyc = 1'b0;
    m_reqack = 1'b0;
  endtask

  task automatic serve_read(input bit port, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] got, want;
    for (int i = 0; i < BEATS; i++) begin
      m_respcyc = 1'b1;
      want      = base + DATA_W'(i);
      m_resp    = want;
      if (port) d_respack = 1'b1;
      else      f_respack = 1'b1;
      #1;
      got = port ? d_resp : f_resp;
      vectors++;
      if ({f_respcyc, d_respcyc, m_respack, f_reqack, d_reqack, got} !== {~port, port, 3'b100, want}) begin
        miscompares++;
        $display("FAIL read_beat port=%0d beat=%0d: got f/d respcyc=%b%b respack=%b reqack=%b%b data=%h, want %b%b 1 00 %h",
                 port, i, f_respcyc, d_respcyc, m_respack, f_reqack, d_reqack, got, ~port, port, want);
      end
      tick();
    end
    m_respcyc = 1'b0;
    f_respack = 1'b0;
    d_respack = 1'b0;
    #1;
    vectors++;
    if (m_reqcyc !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_gap port=%0d: got m_reqcyc=%b, want 0", port, m_reqcyc);
    end
  endtask

  task automatic test_reset();
    f_reqcyc = 1'b1; d_reqcyc = 1'b1; m_reqack = 1'b1; m_respcyc = 1'b1; m_resp = 64'hDEAD;
    f_respack = 1'b1; d_respack = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({f_reqack, d_reqack, f_respcyc, d_respcyc, m_reqcyc, m_respack, f_resp, d_resp, m_req, m_reqtag} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got reqack=%b%b respcyc=%b%b m_reqcyc=%b m_respack=%b m_req=%h, want all 0",
               f_reqack, d_reqack, f_respcyc, d_respcyc, m_reqcyc, m_respack, m_req);
    end
    f_reqcyc = 1'b0; d_reqcyc = 1'b0; m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0;
    f_respack = 1'b0; d_respack = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_tie_first();
    f_reqcyc = 1'b1; f_req = 64'h3000; f_reqtag = F_RTAG;
    d_reqcyc = 1'b1; d_req = 64'h4000; d_reqtag = D_RTAG;
    tick();
    expect_grant(1'b0, 64'h3000, F_RTAG);
    serve_read(1'b0, 64'h10);
    tick();
    expect_grant(1'b1, 64'h4000, D_RTAG);
    serve_read(1'b1, 64'h20);
  endtask

  task automatic test_fetch_read();
    f_reqcyc = 1'b1; f_req = 64'h1000; f_reqtag = F_RTAG;
    #1;
    vectors++;
    if (m_reqcyc !== 1'b0) begin
      miscompares++;
      $display("FAIL grant_latency: got m_reqcyc=%b in request cycle, want 0", m_reqcyc);
    end
    tick();
    expect_grant(1'b0, 64'h1000, F_RTAG);
    serve_read(1'b0, 64'h0);
  endtask

  task automatic test_rr_tie();
    bit win;
    logic [DATA_W-1:0] a_win, a_lose;
    logic [TAG_W-1:0]  t_win, t_lose;
`ifdef SYSBUS_ARB_FETCH_PRIORITY_EN
    win = 1'b0;
`else
    win = 1'b1;
`endif
    a_win  = win ? 64'h4100 : 64'h3100;
    a_lose = win ? 64'h3100 : 64'h4100;
    t_win  = win ? D_RTAG : F_RTAG;
    t_lose = win ? F_RTAG : D_RTAG;
    f_reqcyc = 1'b1; f_req = 64'h3100; f_reqtag = F_RTAG;
    d_reqcyc = 1'b1; d_req = 64'h4100; d_reqtag = D_RTAG;
    tick();
    expect_grant(win, a_win, t_win);
    serve_read(win, 64'h30);
    tick();
    expect_grant(~win, a_lose, t_lose);
    serve_read(~win, 64'h50);
  endtask

  task automatic test_data_write();
    logic [DATA_W-1:0] want;
    m_reqack = 1'b1;
    d_reqcyc = 1'b1; d_req = 64'h2000; d_reqtag = D_WTAG;
    tick();
    #1;
    vectors++;
    if ({m_reqcyc, m_req, m_reqtag, d_reqack, f_reqack} !== {1'b1, 64'h2000, D_WTAG, 2'b10}) begin
      miscompares++;
      $display("FAIL write_hdr: got cyc=%b req=%h tag=%h d/f reqack=%b%b, want 1 2000 %h 10",
               m_reqcyc, m_req, m_reqtag, d_reqack, f_reqack, D_WTAG);
    end
    tick();
    for (int i = 0; i < BEATS; i++) begin
      want  = 64'hA0 + DATA_W'(i);
      d_req = want;
      #1;
      vectors++;
      if ({m_reqcyc, m_req, d_reqack, m_respack} !== {1'b1, want, 2'b10}) begin
        miscompares++;
        $display("FAIL write_beat %0d: got cyc=%b req=%h d_reqack=%b m_respack=%b, want 1 %h 1 0",
                 i, m_reqcyc, m_req, d_reqack, m_respack, want);
      end
      tick();
    end
    d_reqcyc = 1'b0;
    m_reqack = 1'b0;
    #1;
    vectors++;
    if ({m_reqcyc, m_respack, d_reqack} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_done: got m_reqcyc=%b m_respack=%b d_reqack=%b, want 000", m_reqcyc, m_respack, d_reqack);
    end
    tick();
  endtask

  task automatic test_stalled_response();
    f_reqcyc = 1'b1; f_req = 64'h5000; f_reqtag = F_RTAG;
    tick();
    expect_grant(1'b0, 64'h5000, F_RTAG);
    for (int i = 0; i < BEATS; i++) begin
      if (i == 3) begin
        for (int s = 0; s < 3; s++) begin
          m_respcyc = 1'b1; m_resp = 64'h3; f_respack = 1'b0;
          #1;
          vectors++;
          if ({f_respcyc, m_respack} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_cycle %0d: got f_respcyc=%b m_respack=%b, want 1 0", s, f_respcyc, m_respack);
          end
          tick();
        end
      end
      m_respcyc = 1'b1; m_resp = DATA_W'(i); f_respack = 1'b1;
      #1;
      vectors++;
      if ({f_respcyc, m_respack, f_resp} !== {2'b11, DATA_W'(i)}) begin
        miscompares++;
        $display("FAIL stall_beat %0d: got f_respcyc=%b m_respack=%b data=%h, want 1 1 %h",
                 i, f_respcyc, m_respack, f_resp, i);
      end
      tick();
    end
    m_resp = 64'hEE;
    #1;
    vectors++;
    if ({f_respcyc, d_respcyc, m_respack} !== 3'b000) begin
      miscompares++;
      $display("FAIL beat_total: extra beat forwarded, f/d respcyc=%b%b m_respack=%b, want 000",
               f_respcyc, d_respcyc, m_respack);
    end
    m_respcyc = 1'b0; f_respack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_rdata();
    d_reqcyc = 1'b1; d_req = 64'h6000; d_reqtag = D_RTAG;
    tick();
    expect_grant(1'b1, 64'h6000, D_RTAG);
    for (int i = 0; i < 3; i++) begin
      m_respcyc = 1'b1; m_resp = DATA_W'(i); d_respack = 1'b1;
      tick();
    end
    m_resp = 64'h99;
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({f_reqack, d_reqack, f_respcyc, d_respcyc, m_reqcyc, m_respack, f_resp, d_resp, m_req, m_reqtag} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got respcyc=%b%b m_respack=%b d_resp=%h, want all 0",
               f_respcyc, d_respcyc, m_respack, d_resp);
    end
    tick();
    vectors++;
    if ({d_respcyc, m_respack} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_hold: got d_respcyc=%b m_respack=%b, want 00", d_respcyc, m_respack);
    end
    reset = 1'b1;
    m_respcyc = 1'b0; d_respack = 1'b0;
    tick();
    d_reqcyc = 1'b1; d_req = 64'h7000; d_reqtag = D_RTAG;
    tick();
    expect_grant(1'b1, 64'h7000, D_RTAG);
    serve_read(1'b1, 64'h40);
  endtask

  task automatic test_stray_response();
    m_respcyc = 1'b1; m_resp = 64'h55; f_respack = 1'b1; d_respack = 1'b1;
    #1;
    vectors++;
    if ({f_respcyc, d_respcyc, m_respack, f_resp, d_resp} !== '0) begin
      miscompares++;
      $display("FAIL stray_resp: got f/d respcyc=%b%b m_respack=%b f_resp=%h d_resp=%h, want all 0",
               f_respcyc, d_respcyc, m_respack, f_resp, d_resp);
    end
    tick();
    m_respcyc = 1'b0; f_respack = 1'b0; d_respack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tie_first();
    tick();
    test_fetch_read();
    tick();
    test_rr_tie();
    tick();
    test_data_write();
    test_stalled_response();
    test_reset_mid_rdata();
    tick();
    test_stray_response();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
